// File: rtl/io_periph.sv
// Memory-mapped IO block: LED register plus a FIFO-buffered 8N1 UART transmitter.
// Register selects are one-hot on the word address; the serializer drains the FIFO one frame at a time.
module io_periph #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic        IO_mem_wr,
  input  logic [31:0] IO_mem_wdata,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  LEDS,
  output logic        UART_TX
);

  localparam int DIV    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("io_periph: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_periph: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [5:0]        leds_r;
  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              ovf_r;
  state_t            state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              tx_r;

  logic sel_led_s, sel_data_s, sel_stat_s;
  logic full_s, empty_s, push_s, pop_s, ovf_evt_s, clr_s, busy_s, baud_last_s;
  logic [4:0]  count5_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign sel_led_s   = IO_mem_addr[2];
  assign sel_data_s  = IO_mem_addr[3];
  assign sel_stat_s  = IO_mem_addr[4];
  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign push_s      = IO_mem_wr & sel_data_s & ~full_s;
  assign ovf_evt_s   = IO_mem_wr & sel_data_s & full_s;
  assign clr_s       = IO_mem_wr & sel_stat_s;
  assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
  assign busy_s      = (state_r != ST_IDLE) | ~empty_s;
  assign baud_last_s = (baud_r == BAUD_W'(DIV - 1));
  assign count5_s    = 5'(count_r);
  assign status_s    = {21'd0, ovf_r, full_s, busy_s, 3'd0, count5_s};
  assign unused_s    = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

  assign LEDS    = leds_r;
  assign UART_TX = tx_r;

  // Read mux: status wins over LEDS when both selects are set.
  always_comb begin
    IO_mem_rdata = 32'd0;
    if (sel_stat_s) begin
      IO_mem_rdata = status_s;
    end else if (sel_led_s) begin
      IO_mem_rdata = {26'd0, leds_r};
    end else begin
      IO_mem_rdata = 32'd0;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= IO_mem_wdata[7:0];
    end
  end

  // LED register, FIFO pointers/count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_r   <= 6'd0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (IO_mem_wr && sel_led_s) leds_r <= IO_mem_wdata[5:0];
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // An overflow in the same cycle as a clear must leave the flag set.
      if (ovf_evt_s)  ovf_r <= 1'b1;
      else if (clr_s) ovf_r <= 1'b0;
    end
  end

  // Serializer: tx_r is loaded with the level of the next period at each transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            baud_r  <= {BAUD_W{1'b0}};
            tx_r    <= 1'b0;
            state_r <= ST_START;
          end else begin
            tx_r <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_last_s) begin
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= ST_DATA;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_s) begin
            baud_r  <= {BAUD_W{1'b0}};
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_last_s) begin
            baud_r  <= {BAUD_W{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
          tx_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_periph.sv
// Self-checking bench for io_periph: expected UART frames are queued as bytes are written
// and compared cycle by cycle against the serial line as each frame appears.
module tb_io_periph;

  localparam int DIV = 10;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IO_mem_addr;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_wdata;
  logic [31:0] IO_mem_rdata;
  logic [5:0]  LEDS;
  logic        UART_TX;

  io_periph dut (
    .clk          (clk),
    .reset        (reset),
    .IO_mem_addr  (IO_mem_addr),
    .IO_mem_wr    (IO_mem_wr),
    .IO_mem_wdata (IO_mem_wdata),
    .IO_mem_rdata (IO_mem_rdata),
    .LEDS         (LEDS),
    .UART_TX      (UART_TX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  bit     mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    IO_mem_addr  = a;
    IO_mem_wdata = d;
    IO_mem_wr    = 1'b1;
    @(negedge clk);
    IO_mem_wr    = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    IO_mem_addr = a;
    #1;
    d = IO_mem_rdata;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Serial monitor: every cycle of a frame is compared with the expected level.
  initial begin : uart_mon
    int         start_c;
    int         errs;
    int         idx;
    logic       exp_bit;
    logic [7:0] got_b;
    frame_t     e;
    bit         have;
    forever begin
      @(negedge clk);
      if (mon_en && UART_TX === 1'b0) begin
        start_c = cyc;
        errs    = 0;
        got_b   = 8'h00;
        have    = (exp_q.size() > 0);
        e       = have ? exp_q[0] : '{8'h00, -1};
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          idx = i / DIV;
          if (idx == 0)      exp_bit = 1'b0;
          else if (idx == 9) exp_bit = 1'b1;
          else               exp_bit = e.data[idx-1];
          if ((i % DIV) == DIV / 2 && idx >= 1 && idx <= 8) got_b[idx-1] = UART_TX;
          if (UART_TX !== exp_bit) errs++;
        end
        check_eq("frame_expected", {31'd0, have}, 32'd1);
        if (have) begin
          check_eq("frame_data", {24'd0, got_b}, {24'd0, e.data});
          if (e.start >= 0) check_eq("frame_start", 32'(start_c), 32'(e.start));
          check_eq("frame_shape", 32'(errs), 32'd0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int          t0;
    int          lows;

    reset        = 1'b1;
    IO_mem_wr    = 1'b0;
    IO_mem_addr  = 32'd0;
    IO_mem_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("reset_leds", {26'd0, LEDS}, 32'd0);
    check_eq("reset_tx", {31'd0, UART_TX}, 32'd1);
    io_read(32'h010, rd);
    check_eq("reset_status", rd, 32'd0);
    @(negedge clk);
    mon_en = 1'b1;

    // LED register write and readback
    io_write(32'h004, 32'h0000_002A);
    check_eq("leds_write", {26'd0, LEDS}, 32'h2A);
    io_read(32'h004, rd);
    check_eq("leds_read", rd, 32'h0000_002A);
    io_read(32'h008, rd);
    check_eq("data_reg_read_zero", rd, 32'd0);
    @(negedge clk);

    // Single byte: frame timing and busy release
    t0 = cyc;
    exp_q.push_back('{8'h55, t0 + 2});
    io_write(32'h008, 32'h0000_0155);
    wait_until(t0 + 101);
    io_read(32'h010, rd);
    check_eq("busy_at_last_stop", rd, 32'h0000_0100);
    @(negedge clk);
    io_read(32'h010, rd);
    check_eq("idle_after_frame", rd, 32'h0000_0000);
    drain(300);

    // Five back-to-back bytes from idle
    t0 = cyc;
    for (int k = 0; k < 5; k++) exp_q.push_back('{8'h41 + 8'(k), t0 + 2 + k * (FRAME + 1)});
    for (int k = 0; k < 5; k++) io_write(32'h008, 32'h41 + 32'(k));
    io_read(32'h010, rd);
    check_eq("b2b_no_overflow", rd & 32'h0000_0400, 32'd0);
    drain(800);

    // Six bytes: the sixth is dropped and flags overflow
    t0 = cyc;
    for (int k = 0; k < 5; k++) exp_q.push_back('{8'h61 + 8'(k), t0 + 2 + k * (FRAME + 1)});
    for (int k = 0; k < 6; k++) io_write(32'h008, 32'h61 + 32'(k));
    io_read(32'h010, rd);
    check_eq("overflow_status", rd, 32'h0000_0704);
    io_write(32'h010, 32'hFFFF_FFFF);
    io_read(32'h010, rd);
    check_eq("overflow_cleared", rd, 32'h0000_0304);
    drain(800);

    // Multi-select write hits LEDS and UART data; status has read priority
    t0 = cyc;
    exp_q.push_back('{8'h3F, t0 + 2});
    io_write(32'h00C, 32'h0000_003F);
    check_eq("multi_sel_leds", {26'd0, LEDS}, 32'h3F);
    io_read(32'h014, rd);
    check_eq("status_priority", rd, 32'h0000_0101);
    drain(300);

    // Reset mid-frame with bytes queued, write during reset is ignored
    mon_en = 1'b0;
    t0 = cyc;
    io_write(32'h008, 32'h00);
    io_write(32'h008, 32'h11);
    io_write(32'h008, 32'h22);
    wait_until(t0 + 40);
    io_read(32'h010, rd);
    check_eq("pre_reset_status", rd, 32'h0000_0102);
    check_eq("pre_reset_tx_low", {31'd0, UART_TX}, 32'd0);
    reset        = 1'b1;
    IO_mem_addr  = 32'h004;
    IO_mem_wdata = 32'h15;
    IO_mem_wr    = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    IO_mem_wr = 1'b0;
    check_eq("abort_tx_high", {31'd0, UART_TX}, 32'd1);
    check_eq("abort_leds", {26'd0, LEDS}, 32'd0);
    io_read(32'h010, rd);
    check_eq("abort_status", rd, 32'd0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) lows++;
    end
    check_eq("no_frames_after_abort", 32'(lows), 32'd0);
    io_read(32'h010, rd);
    check_eq("final_status", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
